// File: rtl/norm_left_shift.sv
// Post-add normalizer: left-shifts a mantissa until its MSB is set, decrementing the exponent.
// Define FAST_LZC_EN for a single-cycle priority-encoder + barrel-shift variant.
module norm_left_shift #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned EXP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_mant,
    input  logic [EXP_W-1:0]         in_exp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_mant,
    output logic [EXP_W-1:0]         out_exp,
    output logic [$clog2(WIDTH)-1:0] out_shamt,
    output logic                     out_zero,
    output logic                     out_underflow
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [SH_W-1:0]   shamt_q, shamt_d;
    logic              zero_q, zero_d;
    logic              unf_q, unf_d;

    logic accept;
    logic in_zero;

    assign accept  = in_valid & (state_q == StIdle);
    assign in_zero = (in_mant == '0);

`ifdef FAST_LZC_EN
    logic [SH_W-1:0] lz;
    logic [SH_W-1:0] k;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        lz = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_mant[i]) lz = SH_W'(WIDTH - 1 - i);
        end
        if (EXP_W'(lz) < in_exp) k = lz;
        else                     k = SH_W'(in_exp);
    end
`else
    logic idle_done;
    logic shift_done;

    assign idle_done  = in_zero | in_mant[WIDTH-1] | (in_exp == '0);
    // Looks at the bits that will be MSB / exponent after this cycle's shift.
    assign shift_done = mant_q[WIDTH-2] | (exp_q == EXP_W'(1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
`ifdef FAST_LZC_EN
                if (accept) state_d = StHold;
`else
                if (accept) state_d = idle_done ? StHold : StShift;
`endif
            end
            StShift: begin
`ifndef FAST_LZC_EN
                if (shift_done) state_d = StHold;
`else
                state_d = StIdle;
`endif
            end
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mant_d  = mant_q;
        exp_d   = exp_q;
        shamt_d = shamt_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
        if (accept) begin
            zero_d = in_zero;
`ifdef FAST_LZC_EN
            mant_d  = in_mant << k;
            exp_d   = in_zero ? '0 : in_exp - EXP_W'(k);
            shamt_d = in_zero ? '0 : k;
            unf_d   = ~in_zero & (exp_d == '0);
`else
            mant_d  = in_mant;
            exp_d   = in_zero ? '0 : in_exp;
            shamt_d = '0;
            unf_d   = ~in_zero & (in_exp == '0);
`endif
        end
`ifndef FAST_LZC_EN
        else if (state_q == StShift) begin
            mant_d  = {mant_q[WIDTH-2:0], 1'b0};
            exp_d   = exp_q - EXP_W'(1);
            shamt_d = shamt_q + SH_W'(1);
            unf_d   = (exp_q == EXP_W'(1));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q  <= '0;
            exp_q   <= '0;
            shamt_q <= '0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            shamt_q <= shamt_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        in_ready      = (state_q == StIdle);
        out_valid     = (state_q == StHold);
        out_mant      = mant_q;
        out_exp       = exp_q;
        out_shamt     = shamt_q;
        out_zero      = zero_q;
        out_underflow = unf_q;
    end

endmodule

// File: tb/tb_norm_left_shift.sv
// Self-checking bench for norm_left_shift: directed vector table, stall/reset sequences and
// randomized transactions against an arithmetic reference model.
module tb_norm_left_shift;

    localparam int W = 8;
    localparam int E = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_mant = '0;
    logic [E-1:0] in_exp = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_mant;
    logic [E-1:0] out_exp;
    logic [2:0]   out_shamt;
    logic         out_zero;
    logic         out_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    norm_left_shift #(.WIDTH(W), .EXP_W(E)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mant       (in_mant),
        .in_exp        (in_exp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mant      (out_mant),
        .out_exp       (out_exp),
        .out_shamt     (out_shamt),
        .out_zero      (out_zero),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] mant;
        logic [E-1:0] exp;
        logic [W-1:0] x_mant;
        logic [E-1:0] x_exp;
        int           x_shamt;
        logic         x_zero;
        logic         x_unf;
        int           x_shifts;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    function automatic int exp_latency(input int shifts);
`ifdef FAST_LZC_EN
        return 0;
`else
        return shifts;
`endif
    endfunction

    // Reference: multiply by two while below the MSB weight and the exponent allows.
    function automatic vec_t ref_model(input logic [W-1:0] m, input logic [E-1:0] e);
        vec_t v;
        int mm = int'(m);
        int ee = int'(e);
        int k  = 0;
        v.mant = m;
        v.exp  = e;
        if (mm == 0) begin
            ee = 0;
        end else begin
            while (mm < (1 << (W - 1)) && ee > 0) begin
                mm = mm * 2;
                ee = ee - 1;
                k  = k + 1;
            end
        end
        v.x_mant   = W'(mm);
        v.x_exp    = E'(ee);
        v.x_shamt  = k;
        v.x_zero   = (m == 0);
        v.x_unf    = (ee == 0) && (m != 0);
        v.x_shifts = k;
        return v;
    endfunction

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, ".mant"},  32'(out_mant),      32'(v.x_mant));
        chk({tag, ".exp"},   32'(out_exp),       32'(v.x_exp));
        chk({tag, ".shamt"}, 32'(out_shamt),     32'(v.x_shamt));
        chk({tag, ".zero"},  32'(out_zero),      32'(v.x_zero));
        chk({tag, ".unf"},   32'(out_underflow), 32'(v.x_unf));
    endtask

    task automatic txn(input string tag, input vec_t v, input int stall);
        int waited = 0;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_mant  = v.mant;
        in_exp   = v.exp;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_mant  = W'($urandom);
        in_exp   = E'($urandom);
        while (!out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, ".latency"}, 32'(waited), 32'(exp_latency(v.x_shifts)));
        chk_out(tag, v);
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;  // must be ignored while holding
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            chk_out({tag, ".hold"}, v);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h80, 8'd10, 8'h80, 8'd10, 0, 1'b0, 1'b0, 0};
        vecs[1] = '{8'h05, 8'd20, 8'hA0, 8'd15, 5, 1'b0, 1'b0, 5};
        vecs[2] = '{8'h00, 8'd7,  8'h00, 8'd0,  0, 1'b1, 1'b0, 0};
        vecs[3] = '{8'h01, 8'd3,  8'h08, 8'd0,  3, 1'b0, 1'b1, 3};
        vecs[4] = '{8'h40, 8'd0,  8'h40, 8'd0,  0, 1'b0, 1'b1, 0};

        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out_mant",  32'(out_mant),  32'd0);
        chk("rst.out_exp",   32'(out_exp),   32'd0);
        chk("rst.out_shamt", 32'(out_shamt), 32'd0);
        chk("rst.out_zero",  32'(out_zero),  32'd0);
        chk("rst.out_unf",   32'(out_underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) txn($sformatf("vec%0d", i), vecs[i], 0);

        txn("stall", vecs[1], 3);

        // Reset in the middle of a transaction discards it.
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = 8'h05;
        in_exp   = 8'd20;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready",  32'(in_ready),  32'd1);
        chk("midrst.out_mant",  32'(out_mant),  32'd0);
        chk("midrst.out_exp",   32'(out_exp),   32'd0);
        chk("midrst.out_shamt", 32'(out_shamt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("midrst.no_valid", 32'(out_valid), 32'd0);
        end
        txn("after_rst", vecs[0], 0);

        for (int t = 0; t < 200; t++) begin
            logic [W-1:0] m;
            logic [E-1:0] e;
            m = W'($urandom);
            if ($urandom_range(0, 3) == 0) m = m >> $urandom_range(0, W);
            e = ($urandom_range(0, 1) == 0) ? E'($urandom_range(0, 9)) : E'($urandom);
            txn($sformatf("rnd%0d", t), ref_model(m, e), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
